// File: rtl/frame_loader.sv
// Receives a SYNC-framed byte stream and loads it into parameter memory, top address first.
// Address 0 (the start command) is written only after the frame's checksum has been verified.
module frame_loader #(
    parameter int unsigned FRAME_LEN = 113,
    parameter logic [7:0]  SYNC      = 8'hA5,
    parameter logic [15:0] TIMEOUT   = 16'd50000
) (
    input  logic       clk_LDR,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] w_addr,
    output logic [7:0] wr_data,
    output logic       write,
    output logic       read,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [7:0] LastAddr = 8'(FRAME_LEN - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StCheck, StCommit} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  held_q, held_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        write_q, write_d;
    logic        read_q, read_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;

    always_ff @(posedge clk_LDR or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            sum_q   <= 8'd0;
            held_q  <= 8'd0;
            tmo_q   <= 16'd0;
            addr_q  <= 8'd0;
            data_q  <= 8'd0;
            write_q <= 1'b0;
            read_q  <= 1'b1;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            held_q  <= held_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            write_q <= write_d;
            read_q  <= read_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        held_d  = held_q;
        tmo_d   = tmo_q;
        addr_d  = addr_q;
        data_d  = data_q;
        write_d = 1'b0;
        read_d  = read_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Readout resumes one clock after an error pulse
                if (err_q) read_d = 1'b1;
                if (rx_valid && (rx_data == SYNC)) begin
                    state_d = StLoad;
                    sum_d   = 8'd0;
                    cnt_d   = LastAddr;
                    tmo_d   = 16'd0;
                    read_d  = 1'b0;
                end
            end
            StLoad, StCheck: begin
                if (rx_valid) begin
                    tmo_d = 16'd0;
                    if (state_q == StLoad) begin
                        sum_d = sum_q + rx_data;
                        if (cnt_q == 8'd0) begin
                            held_d  = rx_data;
                            state_d = StCheck;
                        end else begin
                            write_d = 1'b1;
                            addr_d  = cnt_q;
                            data_d  = rx_data;
                            cnt_d   = cnt_q - 8'd1;
                        end
                    end else if (rx_data == sum_q) begin
                        write_d = 1'b1;
                        addr_d  = 8'd0;
                        data_d  = held_q;
                        ok_d    = 1'b1;
                        state_d = StCommit;
                    end else begin
                        err_d   = 1'b1;
                        held_d  = 8'd0;
                        state_d = StIdle;
                    end
                end else if (tmo_q == TIMEOUT - 16'd1) begin
                    err_d   = 1'b1;
                    held_d  = 8'd0;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            StCommit: begin
                state_d = StIdle;
                read_d  = 1'b1;
                held_d  = 8'd0;
            end
            default: state_d = StIdle;
        endcase
    end

    assign w_addr    = addr_q;
    assign wr_data   = data_q;
    assign write     = write_q;
    assign read      = read_q;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_frame_loader.sv
// Scoreboard bench for frame_loader: expected writes are queued as bytes are sent and
// popped by a negedge monitor whenever the loader strobes write.
module tb_frame_loader;

    localparam int unsigned FrameLen = 113;
    localparam logic [7:0]  Sync     = 8'hA5;
    localparam logic [15:0] Timeout  = 16'd300;

    logic       clk_LDR = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] w_addr;
    logic [7:0] wr_data;
    logic       write;
    logic       read;
    logic       frame_ok;
    logic       frame_err;
    logic       busy;

    frame_loader #(
        .FRAME_LEN (FrameLen),
        .SYNC      (Sync),
        .TIMEOUT   (Timeout)
    ) dut (
        .clk_LDR   (clk_LDR),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .w_addr    (w_addr),
        .wr_data   (wr_data),
        .write     (write),
        .read      (read),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk_LDR = ~clk_LDR;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] pl [FrameLen];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_LDR) begin
        if (write === 1'b1) begin
            check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(w_addr), 32'(mon_e.addr));
                check("wr_data", 32'(wr_data), 32'(mon_e.data));
                check("ok_with_addr0", 32'(frame_ok), 32'(mon_e.addr == 8'd0));
            end
        end else if (frame_ok === 1'b1) begin
            check("ok_without_wr", 32'(write), 32'd1);
        end
        if (busy === 1'b1) check("read_low_busy", 32'(read), 32'd0);
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_LDR);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk_LDR);
        rx_valid = 1'b0;
        rx_data  = 8'd0;
    endtask

    task automatic fill_default();
        for (int i = 0; i < int'(FrameLen); i++)
            pl[i] = (i == int'(FrameLen) - 1) ? 8'd255 : 8'(i + 1);
    endtask

    // SYNC followed by the first n payload bytes; data bytes queue their expected writes.
    task automatic send_payload(input int n);
        send_byte(Sync);
        for (int i = 0; i < n; i++) begin
            if (i < int'(FrameLen) - 1) exp_q.push_back({8'(int'(FrameLen) - 1 - i), pl[i]});
            send_byte(pl[i]);
        end
    endtask

    task automatic finish_frame(input bit good);
        logic [7:0] ck;
        ck = 8'd0;
        for (int i = 0; i < int'(FrameLen); i++) ck = ck + pl[i];
        if (good) exp_q.push_back({8'd0, pl[FrameLen-1]});
        send_byte(good ? ck : ck + 8'd1);
        check("frame_ok", 32'(frame_ok), 32'(good));
        check("frame_err", 32'(frame_err), 32'(!good));
        check("read_low_end", 32'(read), 32'd0);
        @(negedge clk_LDR);
        check("busy_after", 32'(busy), 32'd0);
        check("read_after", 32'(read), 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_write"}, 32'(write), 32'd0);
        check({tag, "_addr"}, 32'(w_addr), 32'd0);
        check({tag, "_data"}, 32'(wr_data), 32'd0);
        check({tag, "_ok"}, 32'(frame_ok), 32'd0);
        check({tag, "_err"}, 32'(frame_err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_read"}, 32'(read), 32'd1);
    endtask

    initial begin
        logic [7:0] noise [3];
        int n;
        noise[0] = 8'h00;
        noise[1] = 8'hFF;
        noise[2] = 8'h5A;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        #12;
        check_reset_outputs("rst");
        repeat (2) @(negedge clk_LDR);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            send_byte(noise[i]);
            check("noise_busy", 32'(busy), 32'd0);
            check("noise_read", 32'(read), 32'd1);
        end

        fill_default();
        send_payload(int'(FrameLen));
        finish_frame(1'b1);

        send_payload(int'(FrameLen));
        finish_frame(1'b0);

        // Timeout: count clocks from the last write to the error pulse
        send_payload(50);
        n = 0;
        while (frame_err !== 1'b1 && n < int'(Timeout) + 20) begin
            @(negedge clk_LDR);
            n++;
        end
        check("tmo_cycles", 32'(n), 32'(Timeout));
        check("tmo_busy", 32'(busy), 32'd0);
        @(negedge clk_LDR);
        check("tmo_read", 32'(read), 32'd1);
        check("tmo_queue", 32'(exp_q.size()), 32'd0);
        send_payload(int'(FrameLen));
        finish_frame(1'b1);

        // Reset mid-frame must act without a clock edge
        send_payload(60);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        exp_q.delete();
        @(negedge clk_LDR);
        #2 rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            send_byte(8'(i));
            check("nosync_busy", 32'(busy), 32'd0);
        end
        send_payload(int'(FrameLen));
        finish_frame(1'b1);

        // SYNC value inside the payload is plain data
        pl[9] = Sync;
        send_payload(int'(FrameLen));
        finish_frame(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
